// File: rtl/life_gen_engine_pkg.sv
// Shared types, rule constants and width helpers for the Life generation engine.
package life_pkg;

   // Conway B3/S23
   localparam int BIRTH_N    = 3;
   localparam int SURVIVE_LO = 2;
   localparam int SURVIVE_HI = 3;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      CALC      = 2'd1,
      WAIT_SWAP = 2'd2
   } state_e;

   // cell index width
   function automatic int idx_w(input int cols_log2, input int rows_log2);
      return cols_log2 + rows_log2;
   endfunction

   // live-cell count width: must hold SIZE itself
   function automatic int cnt_w(input int cols_log2, input int rows_log2);
      return cols_log2 + rows_log2 + 1;
   endfunction

endpackage

// File: rtl/life_gen_engine_if.sv
// Control / render bus between the timing+control side (master) and the engine (slave).
interface life_gen_engine_if #(
   parameter int COLS_LOG2 = 3,
   parameter int ROWS_LOG2 = 3
);
   import life_pkg::*;

   localparam int IW = idx_w(COLS_LOG2, ROWS_LOG2);
   localparam int CW = cnt_w(COLS_LOG2, ROWS_LOG2);

   logic          frame_tick;
   logic          run;
   logic          step;
   logic          clear;
   logic          load_en;
   logic [IW-1:0] load_addr;
   logic          load_data;
   logic [IW-1:0] rd_addr;
   logic          rd_data;
   logic          busy;
   logic [15:0]   gen_count;
   logic [CW-1:0] alive_count;

   modport master (
      output frame_tick, run, step, clear, load_en, load_addr, load_data, rd_addr,
      input  rd_data, busy, gen_count, alive_count
   );

   modport slave (
      input  frame_tick, run, step, clear, load_en, load_addr, load_data, rd_addr,
      output rd_data, busy, gen_count, alive_count
   );

endinterface

// File: rtl/life_gen_engine_cell_rule.sv
// Combinational B3/S23 rule for one cell given its 3x3 neighbourhood (bit 4 = centre).
module life_cell_rule
   import life_pkg::*;
(
   input  logic [8:0] i_nbhd,
   output logic [3:0] o_count,
   output logic       o_next
);

   logic [3:0] w_cnt;

   // sum the eight neighbours, skipping the centre
   always_comb begin
      w_cnt = 4'd0;
      for (int i = 0; i < 9; i++)
         if (i != 4) w_cnt = w_cnt + {3'd0, i_nbhd[i]};
   end

   assign o_count = w_cnt;
   assign o_next  = (w_cnt == 4'(BIRTH_N)) |
                    (i_nbhd[4] & (w_cnt >= 4'(SURVIVE_LO)) & (w_cnt <= 4'(SURVIVE_HI)));

endmodule

// File: rtl/life_gen_engine.sv
// Double-buffered Game of Life engine: one cell per clk into the hidden bank,
// bank swap on the frame tick after the sweep so the renderer never sees a torn board.
module life_gen_engine
   import life_pkg::*;
#(
   parameter int COLS_LOG2  = 3,
   parameter int ROWS_LOG2  = 3,
   parameter int WRAP       = 0,
   parameter int GEN_PERIOD = 60,
   parameter logic [(1 << (COLS_LOG2 + ROWS_LOG2))-1:0] INIT_PATTERN = '0
)(
   input  logic              clk,
   input  logic              rst_n,
   life_gen_engine_if.slave  bus
);

   localparam int SIZE = 1 << (COLS_LOG2 + ROWS_LOG2);
   localparam int IW   = idx_w(COLS_LOG2, ROWS_LOG2);
   localparam int CW   = cnt_w(COLS_LOG2, ROWS_LOG2);

   function automatic logic [CW-1:0] f_popcount(input logic [SIZE-1:0] v);
      logic [CW-1:0] n;
      n = '0;
      for (int i = 0; i < SIZE; i++) n = n + CW'(v[i]);
      return n;
   endfunction

   localparam logic [CW-1:0] INIT_ALIVE = f_popcount(INIT_PATTERN);

   logic [SIZE-1:0] r_bank0, r_bank1;
   logic            r_disp_sel;
   state_e          r_state;
   logic [IW-1:0]   r_idx;
   logic [CW-1:0]   r_acc;
   logic [7:0]      r_frame_cnt;
   logic [15:0]     r_gen_count;
   logic [CW-1:0]   r_alive;
   logic            r_busy;

   logic [SIZE-1:0]      w_disp;
   logic [ROWS_LOG2-1:0] w_row;
   logic [COLS_LOG2-1:0] w_col;
   logic [8:0]           w_nbhd;
   logic                 w_next;
   logic [3:0]           w_unused_nbr_count;
   logic                 w_period_hit;
   logic                 w_start;

   assign w_disp = r_disp_sel ? r_bank1 : r_bank0;
   assign w_row  = r_idx[IW-1 -: ROWS_LOG2];
   assign w_col  = r_idx[COLS_LOG2-1:0];

   assign w_period_hit = bus.frame_tick & bus.run & (r_frame_cnt == 8'(GEN_PERIOD - 1));
   assign w_start      = w_period_hit | bus.step;

   // Neighbour fetch: coordinates carry one extra bit so that -1 and ROWS/COLS
   // both show up as a set MSB; with WRAP the MSB is simply dropped.
   for (genvar gr = 0; gr < 3; gr++) begin : g_r
      for (genvar gc = 0; gc < 3; gc++) begin : g_c
         logic [ROWS_LOG2:0] w_rr;
         logic [COLS_LOG2:0] w_cc;
         logic               w_off;
         assign w_rr  = {1'b0, w_row} + (ROWS_LOG2+1)'(gr) - (ROWS_LOG2+1)'(1);
         assign w_cc  = {1'b0, w_col} + (COLS_LOG2+1)'(gc) - (COLS_LOG2+1)'(1);
         assign w_off = (WRAP == 0) && (w_rr[ROWS_LOG2] || w_cc[COLS_LOG2]);
         assign w_nbhd[gr*3 + gc] = w_off ? 1'b0
                                  : w_disp[{w_rr[ROWS_LOG2-1:0], w_cc[COLS_LOG2-1:0]}];
      end
   end

   // count is only of interest when probing the rule block; the engine needs next
   life_cell_rule u_rule (
      .i_nbhd  (w_nbhd),
      .o_count (w_unused_nbr_count),
      .o_next  (w_next)
   );

   // frame divider: counts whenever run is high, regardless of engine state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_frame_cnt <= 8'd0;
      else if (bus.frame_tick && bus.run)
         r_frame_cnt <= w_period_hit ? 8'd0 : r_frame_cnt + 8'd1;
   end

   // control FSM with bank storage, sweep index and counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bank0     <= INIT_PATTERN;
         r_bank1     <= '0;
         r_disp_sel  <= 1'b0;
         r_state     <= IDLE;
         r_idx       <= '0;
         r_acc       <= '0;
         r_gen_count <= 16'd0;
         r_alive     <= INIT_ALIVE;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               // a start coinciding with clear/load is intentionally lost
               if (bus.clear) begin
                  if (r_disp_sel) r_bank1 <= '0;
                  else            r_bank0 <= '0;
                  r_alive <= '0;
               end else if (bus.load_en) begin
                  if (r_disp_sel) r_bank1[bus.load_addr] <= bus.load_data;
                  else            r_bank0[bus.load_addr] <= bus.load_data;
               end else if (w_start) begin
                  r_idx   <= '0;
                  r_acc   <= '0;
                  r_state <= CALC;
                  r_busy  <= 1'b1;
               end
            end
            CALC: begin
               if (r_disp_sel) r_bank0[r_idx] <= w_next;
               else            r_bank1[r_idx] <= w_next;
               r_acc <= r_acc + CW'(w_next);
               if (r_idx == IW'(SIZE - 1)) r_state <= WAIT_SWAP;
               else                        r_idx   <= r_idx + IW'(1);
            end
            WAIT_SWAP: begin
               if (bus.frame_tick) begin
                  r_disp_sel  <= ~r_disp_sel;
                  r_gen_count <= r_gen_count + 16'd1;
                  r_alive     <= r_acc;
                  r_state     <= IDLE;
                  r_busy      <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rd_data     = w_disp[bus.rd_addr];
   assign bus.busy        = r_busy;
   assign bus.gen_count   = r_gen_count;
   assign bus.alive_count = r_alive;

endmodule

// File: tb/tb_life_gen_engine.sv
// Directed bench: three engine builds (8x8 edge-dead with blinker seed, 8x8 torus, 16x16 torus)
// share one control stream; each has its own render bus.
module tb_life_gen_engine;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       frame_tick = 1'b0, run = 1'b0, step = 1'b0, clear = 1'b0;
   logic       load_en = 1'b0, load_data = 1'b0;
   logic [7:0] la = 8'd0;
   logic [7:0] ra = 8'd0;

   int nchk = 0;
   int nerr = 0;

   localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;  // 26,27,28
   localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;  // 19,27,35
   localparam logic [63:0] CORNERS = 64'h8100_0000_0000_0081;  // 0,7,56,63

   always #5 clk = ~clk;

   life_gen_engine_if #(.COLS_LOG2(3), .ROWS_LOG2(3)) if0 ();
   life_gen_engine_if #(.COLS_LOG2(3), .ROWS_LOG2(3)) if1 ();
   life_gen_engine_if #(.COLS_LOG2(4), .ROWS_LOG2(4)) if2 ();

   assign if0.frame_tick = frame_tick;  assign if1.frame_tick = frame_tick;  assign if2.frame_tick = frame_tick;
   assign if0.run        = run;         assign if1.run        = run;         assign if2.run        = run;
   assign if0.step       = step;        assign if1.step       = step;        assign if2.step       = step;
   assign if0.clear      = clear;       assign if1.clear      = clear;       assign if2.clear      = clear;
   assign if0.load_en    = load_en;     assign if1.load_en    = load_en;     assign if2.load_en    = load_en;
   assign if0.load_data  = load_data;   assign if1.load_data  = load_data;   assign if2.load_data  = load_data;
   assign if0.load_addr  = la[5:0];     assign if1.load_addr  = la[5:0];     assign if2.load_addr  = la;
   assign if0.rd_addr    = ra[5:0];     assign if1.rd_addr    = ra[5:0];     assign if2.rd_addr    = ra;

   life_gen_engine #(.COLS_LOG2(3), .ROWS_LOG2(3), .WRAP(0), .GEN_PERIOD(60),
                     .INIT_PATTERN(BLINK_H)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
   life_gen_engine #(.COLS_LOG2(3), .ROWS_LOG2(3), .WRAP(1), .GEN_PERIOD(60),
                     .INIT_PATTERN(64'd0)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
   life_gen_engine #(.COLS_LOG2(4), .ROWS_LOG2(4), .WRAP(1), .GEN_PERIOD(60),
                     .INIT_PATTERN(256'd0)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic tick();
      frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
   endtask

   // one manual generation: step, let the largest board finish its sweep, then swap
   task automatic gen();
      step = 1'b1; cyc(); step = 1'b0;
      repeat (270) cyc();
      tick();
   endtask

   task automatic load(input logic [7:0] a, input logic d);
      la = a; load_data = d; load_en = 1'b1; cyc(); load_en = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1; cyc(); clear = 1'b0;
   endtask

   task automatic rd0(output logic [63:0] b);
      for (int i = 0; i < 64; i++) begin ra = 8'(i); #1; b[i] = if0.rd_data; end
   endtask

   task automatic rd1(output logic [63:0] b);
      for (int i = 0; i < 64; i++) begin ra = 8'(i); #1; b[i] = if1.rd_data; end
   endtask

   task automatic rd2(output logic [255:0] b);
      for (int i = 0; i < 256; i++) begin ra = 8'(i); #1; b[i] = if2.rd_data; end
   endtask

   initial begin
      logic [63:0]  b0, b1;
      logic [255:0] b2, glider;

      glider = '0;
      glider[18] = 1'b1; glider[35] = 1'b1;
      glider[49] = 1'b1; glider[50] = 1'b1; glider[51] = 1'b1;

      // ---- reset state
      repeat (3) cyc();
      rst_n = 1'b1;
      cyc();
      chk("rst_busy0",  if0.busy, 0);
      chk("rst_gen0",   if0.gen_count, 0);
      chk("rst_alive0", if0.alive_count, 3);
      chk("rst_alive2", if2.alive_count, 0);
      rd0(b0);
      chk("rst_board0", b0, BLINK_H);

      // ---- run=1 auto-advance: start on tick 60, swap on tick 61
      run = 1'b1;
      for (int k = 1; k <= 121; k++) begin
         tick();
         if (k == 59) begin
            chk("run59_busy", if0.busy, 0);
            chk("run59_gen",  if0.gen_count, 0);
         end
         if (k == 60) begin
            chk("run60_busy", if0.busy, 1);
            rd0(b0);
            chk("run60_board", b0, BLINK_H);
         end
         if (k == 61) begin
            chk("run61_busy",  if0.busy, 0);
            chk("run61_gen",   if0.gen_count, 1);
            chk("run61_alive", if0.alive_count, 3);
            rd0(b0);
            chk("run61_board", b0, BLINK_V);
         end
         if (k == 120) chk("run120_busy", if0.busy, 1);
         if (k == 60 || k == 120) begin
            repeat (270) cyc();
            rd0(b0);
            if (k == 60) begin
               chk("run60_hold_board", b0, BLINK_H);
               chk("run60_hold_busy",  if0.busy, 1);
            end
         end else begin
            repeat (2) cyc();
         end
      end
      chk("run121_gen0",   if0.gen_count, 2);
      chk("run121_gen2",   if2.gen_count, 2);
      chk("run121_busy0",  if0.busy, 0);
      rd0(b0);
      chk("run121_board0", b0, BLINK_H);
      chk("run121_fcnt",   u0.r_frame_cnt, 1);
      run = 1'b0;

      // ---- loaded blinker, manual steps
      do_clear();
      chk("clr_alive0", if0.alive_count, 0);
      rd0(b0);
      chk("clr_board0", b0, 0);
      load(8'd26, 1'b1); load(8'd27, 1'b1); load(8'd28, 1'b1);
      chk("load_alive_stale", if0.alive_count, 0);
      rd0(b0);
      chk("load_board0", b0, BLINK_H);
      gen();
      chk("blk1_gen0",   if0.gen_count, 3);
      chk("blk1_alive0", if0.alive_count, 3);
      rd0(b0); rd1(b1);
      chk("blk1_board0", b0, BLINK_V);
      chk("blk1_board1", b1, BLINK_V);
      gen();
      chk("blk2_gen0", if0.gen_count, 4);
      rd0(b0);
      chk("blk2_board0", b0, BLINK_H);

      // ---- corner block: survives on the torus, dies with dead edges
      do_clear();
      load(8'd0, 1'b1); load(8'd7, 1'b1); load(8'd56, 1'b1); load(8'd63, 1'b1);
      gen();
      rd0(b0); rd1(b1);
      chk("corner_board_wrap",   b1, CORNERS);
      chk("corner_alive_wrap",   if1.alive_count, 4);
      chk("corner_board_nowrap", b0, 0);
      chk("corner_alive_nowrap", if0.alive_count, 0);

      // ---- controls ignored while calculating
      do_clear();
      load(8'd26, 1'b1); load(8'd27, 1'b1); load(8'd28, 1'b1);
      step = 1'b1; cyc(); step = 1'b0;
      repeat (10) cyc();
      step = 1'b1; clear = 1'b1; load_en = 1'b1; la = 8'd0; load_data = 1'b1;
      cyc();
      step = 1'b0; clear = 1'b0; load_en = 1'b0;
      chk("calc_idx",  u0.r_idx, 11);
      chk("calc_busy", if0.busy, 1);
      rd0(b0);
      chk("calc_board_kept", b0, BLINK_H);
      repeat (270) cyc();
      tick();
      chk("calc_gen",   if0.gen_count, 6);
      chk("calc_alive", if0.alive_count, 3);
      chk("calc_done_busy", if0.busy, 0);
      rd0(b0);
      chk("calc_board_next", b0, BLINK_V);
      // clear beats load in IDLE
      clear = 1'b1; load_en = 1'b1; la = 8'd27; load_data = 1'b1;
      cyc();
      clear = 1'b0; load_en = 1'b0;
      rd0(b0);
      chk("clrload_board", b0, 0);
      chk("clrload_alive", if0.alive_count, 0);

      // ---- async reset in the middle of a sweep
      gen();
      chk("pre_rst_sel", u0.r_disp_sel, 1);
      load(8'd27, 1'b1);
      step = 1'b1; cyc(); step = 1'b0;
      repeat (20) cyc();
      chk("pre_rst_idx", u0.r_idx, 20);
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_sel",   u0.r_disp_sel, 0);
      chk("mrst_busy",  if0.busy, 0);
      chk("mrst_gen",   if0.gen_count, 0);
      chk("mrst_fcnt",  u0.r_frame_cnt, 0);
      chk("mrst_alive", if0.alive_count, 3);
      rd0(b0);
      chk("mrst_board", b0, BLINK_H);
      repeat (2) cyc();
      rst_n = 1'b1;
      cyc();

      // ---- glider on the 16x16 torus returns after 64 generations
      do_clear();
      load(8'd18, 1'b1); load(8'd35, 1'b1); load(8'd49, 1'b1);
      load(8'd50, 1'b1); load(8'd51, 1'b1);
      for (int g = 0; g < 64; g++) begin
         gen();
         chk($sformatf("glider_alive_g%0d", g + 1), if2.alive_count, 5);
      end
      chk("glider_gen", if2.gen_count, 64);
      rd2(b2);
      chk("glider_board", b2, glider);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
